// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the Space Monsters display. Divides the system
// clock down to a pixel strobe, runs the horizontal/vertical raster counters,
// decodes the active-low sync pulses and the visible-area flag, and emits
// one-clock per-frame and per-game-step ticks used to pace object motion.
//
// Build option:
//   VGA_GAME_TICK_EN  defined   -> frame counter and game_tick implemented
//                     undefined -> game_tick tied low, GAME_DIV ignored
//
// Ports:
//   clk         in   system clock (only clock)
//   rst         in   synchronous active-high reset
//   pix_en      out  one-clk pixel strobe (every CLK_DIV clks)
//   hCount      out  [9:0] horizontal position, 0..H_TOTAL-1
//   vCount      out  [9:0] vertical position, 0..V_TOTAL-1
//   hSync       out  horizontal sync, active-low
//   vSync       out  vertical sync, active-low
//   bright      out  high inside the visible window
//   frame_tick  out  one-clk pulse in the cycle after the (0,0) wrap
//   game_tick   out  one-clk pulse every GAME_DIV frame_ticks
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int GAME_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick,
    output logic       game_tick
);

    // Divider width; at least one bit even for tiny divide ratios.
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // All raster comparisons are done at 10 bits.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S  = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_E  = 10'(H_ACT_END);
    localparam logic [9:0] V_ACT_S  = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_E  = 10'(V_ACT_END);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_count_q, h_count_d;
    logic [9:0]       v_count_q, v_count_d;
    logic             frame_tick_q, frame_tick_d;
    logic             frame_wrap;

    // Pixel strobe decoded straight from the divider register, so it is
    // low while reset holds the divider at zero.
    assign pix_en = (div_cnt_q == DIV_LAST);

    // ------------------------------------------------------------------
    // Next-state logic for divider and raster counters
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_ONE;
        h_count_d  = h_count_q;
        v_count_d  = v_count_q;
        frame_wrap = 1'b0;

        if (pix_en) begin
            if (h_count_q == H_LAST) begin
                h_count_d = '0;
                if (v_count_q == V_LAST) begin
                    v_count_d  = '0;
                    // Both counters return to (0,0) on this edge.
                    frame_wrap = 1'b1;
                end else begin
                    v_count_d = v_count_q + 10'd1;
                end
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end

        // Registered so the tick lands in the cycle after the wrap edge.
        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            h_count_q    <= '0;
            v_count_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hCount     = h_count_q;
    assign vCount     = v_count_q;
    assign frame_tick = frame_tick_q;

    // ------------------------------------------------------------------
    // Zero-latency decodes from the counter registers
    // ------------------------------------------------------------------
    assign hSync  = !(h_count_q < H_SYNC_W);
    assign vSync  = !(v_count_q < V_SYNC_W);
    assign bright = (h_count_q >= H_ACT_S) && (h_count_q < H_ACT_E) &&
                    (v_count_q >= V_ACT_S) && (v_count_q < V_ACT_E);

    // ------------------------------------------------------------------
    // Game-step tick
    // ------------------------------------------------------------------
`ifdef VGA_GAME_TICK_EN
    localparam int FC_W = (GAME_DIV > 2) ? $clog2(GAME_DIV) : 1;

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(GAME_DIV - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            game_tick_q, game_tick_d;

    // Evaluated on the same edge that launches frame_tick, so game_tick
    // coincides with the frame_tick that returns frame_cnt to zero. With
    // GAME_DIV = 1 the counter sits at zero and game_tick equals frame_tick.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        game_tick_d = 1'b0;
        if (frame_wrap) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                game_tick_d = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            game_tick_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            game_tick_q <= game_tick_d;
        end
    end

    assign game_tick = game_tick_q;
`else
    // Feature compiled out: keep GAME_DIV referenced so it is not flagged.
    logic unused_game_div;
    assign unused_game_div = (GAME_DIV < 1);
    assign game_tick       = 1'b0;
`endif

endmodule
